// File: rtl/seq_gen_pkg.sv
// Shared types, constants and LFSR step function for the operand generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 8'h01;

  localparam int unsigned LFSR_TAP_A = 7;
  localparam int unsigned LFSR_TAP_B = 5;
  localparam int unsigned LFSR_TAP_C = 4;
  localparam int unsigned LFSR_TAP_D = 3;

  // Fibonacci step: shift left, feedback into bit 0 (maximal length, period 255).
  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/seq_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and step enable.
module seq_lfsr8
  import seq_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_advance(q);
    end
  end

endmodule

// File: rtl/seq_operand_gen.sv
// Operand source: LFSR-driven operand_a, stepped ramp operand_b, valid/ready handshake.
// Build option SEQ_OPERAND_GEN_SEED_EN adds a seed input sampled at run start.
module seq_operand_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned B_INIT      = 1,
  parameter int unsigned B_STEP      = 2,
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned NUM_STEPS   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ready,
`ifdef SEQ_OPERAND_GEN_SEED_EN
  input  logic [7:0]       seed,
`endif
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned SCW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [SCW-1:0] STEP_LAST = SCW'(NUM_STEPS - 1);

  state_e           state_q, state_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [SCW-1:0]   step_q, step_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  logic              lfsr_load, lfsr_step;
  logic [LFSR_W-1:0] lfsr_q, lfsr_next, seed_raw, seed_eff;

`ifdef SEQ_OPERAND_GEN_SEED_EN
  assign seed_raw = seed;
`else
  assign seed_raw = LFSR_DEFAULT_SEED;
`endif

  // All-zero is the LFSR lock-up state, so never load it.
  assign seed_eff  = (seed_raw == '0) ? LFSR_DEFAULT_SEED : seed_raw;
  assign lfsr_next = lfsr_advance(lfsr_q);

  seq_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed_eff),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          lfsr_load = 1'b1;
          a_d       = seed_eff[WIDTH-1:0];
          b_d       = WIDTH'(B_INIT);
          hold_d    = '0;
          step_d    = '0;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (valid_q && ready) begin
          lfsr_step = 1'b1;
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (step_q == STEP_LAST) begin
              // Last transfer: operands keep the values just consumed.
              state_d = StDone;
              step_d  = '0;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              step_d = step_q + 1'b1;
              b_d    = b_q + WIDTH'(B_STEP);
              a_d    = lfsr_next[WIDTH-1:0];
            end
          end else begin
            hold_d = hold_q + 1'b1;
            a_d    = lfsr_next[WIDTH-1:0];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign operand_a = a_q;
  assign operand_b = b_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_operand_gen.sv
// Randomised bench for seq_operand_gen against a transfer-indexed reference model.
module tb_seq_operand_gen;

  localparam int W = 4;
  localparam int B_INIT = 1;
  localparam int B_STEP = 2;
  localparam int HOLD = 5;
  localparam int NSTEPS = 10;
  localparam int TOTAL = HOLD * NSTEPS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         ready = 1'b0;
  logic [7:0]   seed = 8'h01;
  logic [W-1:0] operand_a, operand_b;
  logic         valid, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_operand_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .ready     (ready),
`ifdef SEQ_OPERAND_GEN_SEED_EN
    .seed      (seed),
`endif
    .operand_a (operand_a),
    .operand_b (operand_b),
    .valid     (valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: value stream indexed by transfer number k.
  function automatic int model_a(input int k);
    logic [7:0] s;
    s = (seed == 8'h00) ? 8'h01 : seed;
    for (int i = 0; i < k; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return int'(s) % (1 << W);
  endfunction

  function automatic int model_b(input int k);
    return (B_INIT + B_STEP * (k / HOLD)) % (1 << W);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // ready_mode: 0 always 1, 1 pattern 1,0,0, 2 random. abort_at/rst_at: transfer index or -1.
  task automatic do_run(input int ready_mode, input int abort_at, input int rst_at,
                        input bit spam_start, input bit abort_with_start);
    int k = 0;
    int cyc = 0;
    int prev_a = -1;
    bit prev_stall = 1'b0;
    bit prev_valid = 1'b0;
    bit finished = 1'b0;
    start = 1'b1;
    abort = abort_with_start;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("run_entry_valid", valid, 1);
    while (!finished && cyc < 1000) begin
      cyc++;
      if (done) begin
        chk("done_count", k, TOTAL);
        chk("done_after_valid", prev_valid, 1);
        chk("done_hold_a", operand_a, model_a(TOTAL - 1));
        chk("done_hold_b", operand_b, model_b(TOTAL - 1));
        chk("done_valid", valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_quiet("after_done");
        tick();
        chk_quiet("idle_after_done");
        finished = 1'b1;
      end else begin
        chk("run_valid", valid, 1);
        chk("run_busy", busy, 1);
        chk("op_a", operand_a, model_a(k));
        chk("op_b", operand_b, model_b(k));
        if (prev_stall) chk("stall_a", operand_a, prev_a);
        prev_a = operand_a;
        prev_valid = valid;
        case (ready_mode)
          0: ready = 1'b1;
          1: ready = (cyc % 3) == 1;
          default: ready = $urandom_range(0, 1);
        endcase
        if (spam_start) start = $urandom_range(0, 1);
        if (k == abort_at) begin
          ready = 1'b1;
          abort = 1'b1;
          tick();
          abort = 1'b0;
          start = 1'b0;
          chk_quiet("abort_next");
          for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("abort_idle");
          end
          finished = 1'b1;
        end else if (k == rst_at) begin
          ready = 1'b1;
          rst = 1'b1;
          tick();
          rst = 1'b0;
          start = 1'b0;
          chk_quiet("rst_mid");
          chk("rst_mid_a", operand_a, 0);
          chk("rst_mid_b", operand_b, 0);
          for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("rst_idle");
          end
          finished = 1'b1;
        end else begin
          prev_stall = !ready;
          if (ready) k++;
          tick();
        end
      end
    end
    start = 1'b0;
    ready = 1'b0;
    if (!finished) chk("run_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_quiet("reset_idle");
      chk("reset_a", operand_a, 0);
      chk("reset_b", operand_b, 0);
    end

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("abort_in_idle");

    do_run(0, -1, -1, 1'b0, 1'b0);
    do_run(1, -1, -1, 1'b0, 1'b0);
    do_run(0, 11, -1, 1'b0, 1'b0);
    do_run(0, -1, -1, 1'b0, 1'b0);
    do_run(2, -1, -1, 1'b1, 1'b1);
    do_run(0, -1, 30, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) do_run(2, $urandom_range(0, 60), -1, 1'b1, 1'b0);

`ifdef SEQ_OPERAND_GEN_SEED_EN
    seed = 8'h00;
    do_run(0, -1, -1, 1'b0, 1'b0);
    seed = 8'hA5;
    do_run(2, -1, -1, 1'b0, 1'b0);
    seed = 8'($urandom_range(0, 255));
    do_run(2, -1, -1, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
